// File: rtl/rvv_enc_pkg.sv
// Shared types and constants for the RVV instruction encoder.
//   - op-kind enum selecting ALU / load / store / reserved requests
//   - major opcode constants for OP-V, LOAD-FP and STORE-FP
//   - field enums for ALU inst/class, funct3 type, LSU mop/umop/width
//   - packed FIFO entry {illegal, inst[31:0]}
//   - helper that recognises the supported LSU element widths
package rvv_enc_pkg;

   typedef enum logic [1:0] {
      OP_ALU = 2'd0,
      OP_LD  = 2'd1,
      OP_ST  = 2'd2,
      OP_RSV = 2'd3
   } op_kind_e;

   localparam logic [6:0] OPC_VALU  = 7'b1010111;
   localparam logic [6:0] OPC_LOAD  = 7'b0000111;
   localparam logic [6:0] OPC_STORE = 7'b0100111;

   // {class[7:6], funct6[5:0]}; class 00 = OPI, 01 = OPM
   typedef enum logic [7:0] {
      ALU_VADD = 8'h00,
      ALU_VMUL = 8'h65,
      ALU_RSV  = 8'hFF
   } alu_inst_e;

   localparam logic [1:0] CLS_OPI = 2'b00;
   localparam logic [1:0] CLS_OPM = 2'b01;

   typedef enum logic [2:0] {
      OPIVV = 3'b000,
      OPFVV = 3'b001,
      OPMVV = 3'b010,
      OPIVI = 3'b011,
      OPIVX = 3'b100,
      OPFVF = 3'b101,
      OPMVX = 3'b110,
      OPCFG = 3'b111
   } alu_type_e;

   typedef enum logic [1:0] {
      MOP_US = 2'b00,
      MOP_UI = 2'b01,
      MOP_CS = 2'b10,
      MOP_OI = 2'b11
   } lsu_mop_e;

   typedef enum logic [4:0] {
      UMOP_NORMAL    = 5'b00000,
      UMOP_WHOLE_REG = 5'b01000,
      UMOP_MASK      = 5'b01011,
      UMOP_FOF       = 5'b10000
   } lsu_umop_e;

   typedef enum logic [2:0] {
      LSU_W8  = 3'b000,
      LSU_W16 = 3'b101,
      LSU_W32 = 3'b110,
      LSU_W64 = 3'b111
   } lsu_width_e;

   typedef struct packed {
      logic        illegal;
      logic [31:0] inst;
   } enc_entry_t;

   function automatic logic lsu_width_ok(input logic [2:0] w);
      return (w == LSU_W8) || (w == LSU_W16) || (w == LSU_W32) || (w == LSU_W64);
   endfunction

endpackage

// File: rtl/rvv_enc_fifo.sv
// Synchronous DEPTH-entry FIFO with power-of-two wrapping pointers.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push    : write i_data (ignored when full)
//   i_pop     : drop the head entry (ignored when empty)
//   o_data    : head entry, valid whenever o_empty is low
//   o_empty   : no entries held
//   o_count   : current occupancy, 0..DEPTH
module rvv_enc_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 33,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Storage carries no reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (w_do_push && !rst)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rvv_inst_encoder.sv
// RVV instruction encoder: builds 32-bit vector instruction words from
// field-level requests, legality-checks them and queues the result.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : request handshake; in_ready = occupancy < DEPTH
//   in_op           : 0 ALU, 1 load, 2 store, 3 reserved
//   in_alu_*        : {class,funct6} and funct3 for ALU requests
//   in_vm, in_vd, in_vs2, in_src1 : common register / mask fields
//   in_lsu_*        : mop, umop, nf, width for load/store requests
//   out_valid/ready : encoded word handshake
//   out_inst        : encoded word (zero for illegal entries / when idle)
//   out_illegal     : head entry failed the legality check
//   emit_cnt        : words popped, wrapping
//   illegal_cnt     : illegal words queued, saturating
module rvv_inst_encoder
   import rvv_enc_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [7:0]       in_alu_inst,
   input  logic [2:0]       in_alu_type,
   input  logic             in_vm,
   input  logic [4:0]       in_vd,
   input  logic [4:0]       in_vs2,
   input  logic [4:0]       in_src1,
   input  logic [1:0]       in_lsu_mop,
   input  logic [4:0]       in_lsu_umop,
   input  logic [2:0]       in_lsu_nf,
   input  logic [2:0]       in_lsu_width,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_illegal,
   output logic [CNT_W-1:0] emit_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int ENT_W = $bits(enc_entry_t);

   logic [31:0]      w_inst;
   logic             w_illegal;
   logic [4:0]       w_lsu_f2;
   enc_entry_t       w_wr_entry;
   enc_entry_t       w_rd_entry;
   logic [ENT_W-1:0] w_rd_bits;
   logic             w_empty;
   logic [OCC_W-1:0] w_count;
   logic             w_push;
   logic             w_pop;

   logic [CNT_W-1:0] r_emit_cnt;
   logic [CNT_W-1:0] r_illegal_cnt;

   // Field 24:20 of a load/store carries umop for unit-stride, else vs2/rs2.
   assign w_lsu_f2 = (in_lsu_mop == MOP_US) ? in_lsu_umop : in_vs2;

   always_comb begin
      w_inst    = '0;
      w_illegal = 1'b0;
      case (in_op)
         OP_ALU: begin
            w_inst = {in_alu_inst[5:0], in_vm, in_vs2, in_src1, in_alu_type, in_vd, OPC_VALU};
            if (in_alu_inst == ALU_RSV)
               w_illegal = 1'b1;
            if (in_alu_inst[7:6] == CLS_OPI) begin
               if (!((in_alu_type == OPIVV) || (in_alu_type == OPIVI) || (in_alu_type == OPIVX)))
                  w_illegal = 1'b1;
            end else if (in_alu_inst[7:6] == CLS_OPM) begin
               if (!((in_alu_type == OPMVV) || (in_alu_type == OPMVX)))
                  w_illegal = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_LD, OP_ST: begin
            w_inst = {in_lsu_nf, 1'b0, in_lsu_mop, in_vm, w_lsu_f2, in_src1, in_lsu_width, in_vd,
                      (in_op == OP_LD) ? OPC_LOAD : OPC_STORE};
            if (!lsu_width_ok(in_lsu_width))
               w_illegal = 1'b1;
            if (in_lsu_mop == MOP_US) begin
               case (in_lsu_umop)
                  UMOP_NORMAL: ;
                  UMOP_FOF: begin
                     // fault-only-first has no store form
                     if (in_op == OP_ST)
                        w_illegal = 1'b1;
                  end
                  UMOP_MASK: begin
                     if ((in_lsu_width != LSU_W8) || (in_lsu_nf != 3'd0) || !in_vm)
                        w_illegal = 1'b1;
                  end
                  UMOP_WHOLE_REG: begin
                     // whole-register moves: 1, 2, 4 or 8 registers
                     if (!((in_lsu_nf == 3'd0) || (in_lsu_nf == 3'd1) ||
                           (in_lsu_nf == 3'd3) || (in_lsu_nf == 3'd7)) || !in_vm)
                        w_illegal = 1'b1;
                  end
                  default: w_illegal = 1'b1;
               endcase
            end
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_wr_entry.illegal = w_illegal;
   assign w_wr_entry.inst    = w_illegal ? 32'h0 : w_inst;

   assign in_ready  = (w_count < OCC_W'(DEPTH));
   assign out_valid = ~w_empty;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   rvv_enc_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W),
      .CW    (OCC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_wr_entry),
      .i_pop   (w_pop),
      .o_data  (w_rd_bits),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Head storage is unreset, so outputs are forced to zero while empty.
   assign w_rd_entry  = w_rd_bits;
   assign out_inst    = out_valid ? w_rd_entry.inst : 32'h0;
   assign out_illegal = out_valid & w_rd_entry.illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_emit_cnt    <= '0;
         r_illegal_cnt <= '0;
      end else begin
         if (w_pop)
            r_emit_cnt <= r_emit_cnt + CNT_W'(1);
         if (w_push && w_illegal && (r_illegal_cnt != '1))
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
   end

   assign emit_cnt    = r_emit_cnt;
   assign illegal_cnt = r_illegal_cnt;

endmodule

// File: doc/rvv_inst_encoder.md
Name: rvv_inst_encoder

Overview:
Assembles 32-bit RVV instruction words from field-level descriptions (op kind, ALU/LSU inst, funct3 class, register indices, vm, LSU mop/umop/nf/width). It is the encoding counterpart of the backend's instruction decode field definitions. It sits on the stimulus side of the rvv_backend bench and feeds the instruction issue interface. Each request is legality-checked, then queued in a small output FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, output FIFO entries (power of two, ≥2)
CNT_W, 16, width of the emitted/illegal counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_op  in  2  0=ALU, 1=LD, 2=ST, 3=reserved
in_alu_inst  in  8  {class[7:6], funct6[5:0]}; class 00=OPI, 01=OPM
in_alu_type  in  3  funct3 (OPIVV..OPCFG)
in_vm  in  1  mask bit (1=unmasked)
in_vd  in  5  vd / vs3 (store data)
in_vs2  in  5  vs2, or rs2 for strided LSU
in_src1  in  5  vs1 / rs1 / imm[4:0]
in_lsu_mop  in  2  US/UI/CS/OI
in_lsu_umop  in  5  lumop/sumop (US only)
in_lsu_nf  in  3  nf field
in_lsu_width  in  3  width field
out_valid  out  1  encoded word valid
out_ready  in  1  consumer ready
out_inst  out  32  encoded instruction
out_illegal  out  1  entry failed legality check
emit_cnt  out  CNT_W  words popped (wraps)
illegal_cnt  out  CNT_W  illegal words pushed (saturates at all-ones)

Behaviour:
- Reset: FIFO emptied; out_valid=0, out_inst=0, out_illegal=0, emit_cnt=0, illegal_cnt=0. Reset dominates a push/pop in the same cycle and discards in-flight entries.
- in_ready = (occupancy < DEPTH). It depends only on registered occupancy: no same-cycle pop bypass, no combinational path from out_ready.
- Latency: a word accepted at edge N is visible with out_valid=1 after edge N (one cycle) if the FIFO was empty. Otherwise it appears in FIFO order.
- Pop occurs when out_valid&out_ready. Simultaneous push and pop leaves occupancy unchanged. Read and write pointers wrap modulo DEPTH.
- out_inst and out_illegal are held stable while out_valid&!out_ready.
- ALU encoding: [31:26]=alu_inst[5:0], [25]=vm, [24:20]=vs2, [19:15]=src1, [14:12]=alu_type, [11:7]=vd, [6:0]=7'b1010111.
- LD/ST encoding: [31:29]=nf, [28]=0, [27:26]=mop, [25]=vm, [24:20]=umop if mop=US else vs2, [19:15]=src1, [14:12]=width, [11:7]=vd, [6:0]=0000111 (LD) or 0100111 (ST).
- Illegal conditions (any one is sufficient):
  - in_op=3.
  - ALU: alu_inst=8'hFF; class not 00/01; OPI with alu_type not in {OPIVV, OPIVI, OPIVX}; OPM with alu_type not in {OPMVV, OPMVX}.
  - LSU: width not in {000, 101, 110, 111}.
  - mop=US with umop not in {NORMAL, WHOLE_REG, MASK, FOF}.
  - FOF with in_op=ST.
  - MASK with width≠000, nf≠0 or vm=0.
  - WHOLE_REG with nf∉{0,1,3,7} or vm=0.
- Illegal requests are still accepted and queued, with out_inst=32'h0 and out_illegal=1. illegal_cnt increments at push time and saturates.
- emit_cnt increments on every pop, legal or illegal.

Decomposition:
- Shared package rvv_enc_pkg:
  - op-kind enum (ALU/LD/ST/RSV).
  - opcode constants 1010111, 0000111, 0100111.
  - Reuses the existing alu_inst_e, alu_type_e, lsu_mop_e, lsu_umop_e and lsu_width_e enums.
  - A packed struct for the FIFO entry {illegal, inst[31:0]}.
- One sub-module: rvv_enc_fifo, a parameterised DEPTH-entry synchronous FIFO with full/empty and occupancy.
- Encoding and legality logic remain combinational in the top module.

Test Plan:
- vadd.vv v1,v2,v3, vm=1 (op=0, alu_inst=8'h00, type=000, vs2=2, src1=3, vd=1), out_ready=1 -> next cycle out_valid=1, out_inst=32'h022180D7, out_illegal=0, emit_cnt=1.
- vmul.vx v8,v16,x5, vm=0 (alu_inst=8'h65, type=110, vs2=16, src1=5, vd=8) -> out_inst=32'h9502E457.
- vle32.v v4,(x10) (op=1, mop=US, umop=0, width=110, src1=10, vd=4, vm=1, nf=0) -> out_inst=32'h02056207; the same fields with op=2 and umop=FOF -> out_illegal=1, out_inst=0, illegal_cnt=1.
- VADD with alu_type=OPMVV -> out_illegal=1; illegal_cnt then counts 1, 2, 3 across repeats; with CNT_W=2, after 4 illegal words it stays at 3.
- out_ready=0, 3 back-to-back requests -> two accepted, in_ready=0 from the cycle after the second. Raise out_ready -> words emerge in order, the third is accepted one cycle after the first pop, and out_inst is held stable while stalled.
- FIFO holding 2 entries, rst=1 for one cycle with in_valid=1 -> after the edge out_valid=0, both counters are 0, in_ready=1, and the dropped request is not emitted.
